ysyx_22041412_icache: RTL and testbench

Direct-mapped, read-only instruction cache; the responder side of the IFU fetch handshake (if_read_valid/addr in, ready/data out) and of the IFU fence.i handshake. On a miss it refills one line from the memory side through a simple request/beat interface. Sits between the IFU and the memory arbiter; it also provides hit/miss performance counters.

---
 rtl/ysyx_22041412_icache_pkg.sv | 39 +++
 rtl/ysyx_22041412_icache_array.sv | 53 +++++
 rtl/ysyx_22041412_icache.sv | 146 ++++++++++++++
 tb/tb_ysyx_22041412_icache.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_icache_pkg.sv
// Shared types and address helpers for the instruction cache.
// Geometry defaults and state encoding live here.
package ysyx_22041412_icache_pkg;

  localparam int LINES_D  = 64;
  localparam int WPL_D    = 4;
  localparam int ADDR_W_D = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_REFILL = 2'd2,
    S_FENCE  = 2'd3
  } state_t;

  function automatic logic [63:0] idx_of(
    input logic [63:0] a,
    input int          off_w,
    input int          idx_w
  );
    return (a >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(
    input logic [63:0] a,
    input int          off_w,
    input int          idx_w
  );
    return a >> (off_w + idx_w);
  endfunction

  function automatic logic [63:0] word_of(
    input logic [63:0] a,
    input int          off_w
  );
    return (a >> 2) & ((64'd1 << (off_w - 2)) - 64'd1);
  endfunction

endpackage

// File: rtl/ysyx_22041412_icache_array.sv
// Tag, valid and data storage for the direct-mapped icache.
// Reads are combinational; only the valid bits are reset.
module ysyx_22041412_icache_array
  import ysyx_22041412_icache_pkg::*;
#(
  parameter int LINES  = LINES_D,
  parameter int WPL    = WPL_D,
  parameter int TAG_W  = 22,
  parameter int IDX_W  = $clog2(LINES),
  parameter int WSEL_W = $clog2(WPL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WSEL_W-1:0] rd_sel,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              we,
  input  logic [WSEL_W-1:0] wr_sel,
  input  logic [31:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              flush_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WPL];

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx][rd_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (we) data_q[idx][wr_sel] <= wr_data;
  end

endmodule

// File: rtl/ysyx_22041412_icache.sv
// Direct-mapped read-only icache: fetch/fence FSM, line refill,
// and hit/miss performance counters.
module ysyx_22041412_icache
  import ysyx_22041412_icache_pkg::*;
#(
  parameter int LINES          = LINES_D,
  parameter int WORDS_PER_LINE = WPL_D,
  parameter int ADDR_W         = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_read_valid,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              ready_o,
  output logic [31:0]       r_data_o,
  input  logic              fence_i,
  output logic              fence_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [63:0]       hit_count,
  output logic [63:0]       miss_count
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] req_addr;
  logic [WSEL_W-1:0] beat_q;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [31:0]       line_data;
  logic              hit;
  logic              last_beat;
  logic              we;
  logic              tag_we;
  logic              flush;

  assign idx  = IDX_W'(idx_of(64'(req_addr), OFF_W, IDX_W));
  assign tag  = TAG_W'(tag_of(64'(req_addr), OFF_W, IDX_W));
  assign wsel = WSEL_W'(word_of(64'(req_addr), OFF_W));

  assign hit       = line_valid && (line_tag == tag);
  assign last_beat = mem_rvalid &&
                     (beat_q == WSEL_W'(WORDS_PER_LINE - 1));

  ysyx_22041412_icache_array #(
    .LINES  (LINES),
    .WPL    (WORDS_PER_LINE),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .WSEL_W (WSEL_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .rd_sel    (wsel),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .we        (we),
    .wr_sel    (beat_q),
    .wr_data   (mem_rdata),
    .tag_we    (tag_we),
    .wr_tag    (tag),
    .flush_all (flush)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fence_i)            state_d = S_FENCE;
        else if (if_read_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = hit ? S_IDLE : S_REFILL;
      S_REFILL: if (last_beat) state_d = S_LOOKUP;
      S_FENCE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o     = 1'b0;
    r_data_o    = '0;
    fence_ready = 1'b0;
    mem_req     = 1'b0;
    we          = 1'b0;
    tag_we      = 1'b0;
    flush       = 1'b0;
    unique case (1'b1)
      state_q == S_LOOKUP: begin
        ready_o  = hit;
        r_data_o = hit ? line_data : '0;
      end
      state_q == S_REFILL: begin
        mem_req = 1'b1;
        we      = mem_rvalid;
        tag_we  = last_beat;
      end
      state_q == S_FENCE: begin
        fence_ready = 1'b1;
        flush       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr   <= '0;
      mem_addr   <= '0;
      beat_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == S_IDLE && !fence_i && if_read_valid)
        req_addr <= r_addr_i;
      if (state_q == S_LOOKUP) begin
        if (hit) begin
          hit_count <= hit_count + 64'd1;
        end else begin
          miss_count <= miss_count + 64'd1;
          mem_addr   <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          beat_q     <= '0;
        end
      end
      if (state_q == S_REFILL && mem_rvalid)
        beat_q <= beat_q + WSEL_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Directed self-checking bench for the icache.
// Memory model returns per-line word patterns with optional stalls.
module tb_ysyx_22041412_icache;

  logic        clk;
  logic        rst;
  logic        if_read_valid;
  logic [31:0] r_addr_i;
  logic        ready_o;
  logic [31:0] r_data_o;
  logic        fence_i;
  logic        fence_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [63:0] hit_count;
  logic [63:0] miss_count;

  int tests_run = 0;
  int fails = 0;

  ysyx_22041412_icache dut (
    .clk           (clk),
    .rst           (rst),
    .if_read_valid (if_read_valid),
    .r_addr_i      (r_addr_i),
    .ready_o       (ready_o),
    .r_data_o      (r_data_o),
    .fence_i       (fence_i),
    .fence_ready   (fence_ready),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] line_word(input logic [31:0] la, input int k);
    if (la == 32'h8000_0000) return 32'h11 * (k + 1);
    return (la | (k << 2)) ^ 32'hA5A5_0000;
  endfunction

  task automatic fetch(
    input  logic [31:0] a,
    input  int          gap_after,
    input  int          gap_len,
    output logic [31:0] data,
    output int          lat,
    output logic        miss,
    output logic [31:0] maddr,
    output logic        drop
  );
    int beats = 0;
    int gap_cnt = 0;
    logic rdy = 1'b0;
    data = '0; lat = -1; miss = 1'b0; maddr = '0; drop = 1'b0;
    @(posedge clk); #1;
    if_read_valid = 1'b1;
    r_addr_i = a;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if_read_valid = 1'b0;
      mem_rvalid = 1'b0;
      if (ready_o) begin
        rdy = 1'b1; data = r_data_o; lat = i + 1;
        break;
      end
      if (mem_req) begin
        miss = 1'b1;
        maddr = mem_addr;
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else if (beats < 4) begin
          mem_rvalid = 1'b1;
          mem_rdata = line_word(mem_addr, beats);
          beats++;
          if (beats == gap_after) gap_cnt = gap_len;
        end
      end else if (miss) begin
        drop = 1'b1;
      end
    end
    if (!rdy) $display("FAIL fetch_timeout addr %h: no ready_o", a);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_read_valid = 1'b0; r_addr_i = '0;
    fence_i = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", ready_o); end
    tests_run++;
    if (fence_ready !== 1'b0) begin fails++; $display("FAIL rst_fence_ready got %b want 0", fence_ready); end
    tests_run++;
    if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    tests_run++;
    if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    tests_run++;
    if (r_data_o !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", r_data_o); end
    tests_run++;
    if (hit_count !== 64'd0) begin fails++; $display("FAIL rst_hits got %0d want 0", hit_count); end
    tests_run++;
    if (miss_count !== 64'd0) begin fails++; $display("FAIL rst_misses got %0d want 0", miss_count); end
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] d, ma; int lat; logic m, dr;
    fetch(32'h8000_0000, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b1) begin fails++; $display("FAIL cold_miss got %b want 1", m); end
    tests_run++;
    if (ma !== 32'h8000_0000) begin fails++; $display("FAIL cold_mem_addr got %h want 80000000", ma); end
    tests_run++;
    if (d !== 32'h11) begin fails++; $display("FAIL cold_data got %h want 11", d); end
    tests_run++;
    if (lat != 6) begin fails++; $display("FAIL cold_latency got %0d want 6", lat); end
    tests_run++;
    if (miss_count !== 64'd1) begin fails++; $display("FAIL cold_misses got %0d want 1", miss_count); end
    tests_run++;
    if (hit_count !== 64'd1) begin fails++; $display("FAIL cold_hits got %0d want 1", hit_count); end
  endtask

  task automatic test_hits();
    logic [31:0] d, ma; int lat; logic m, dr;
    fetch(32'h8000_0004, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b0 || lat != 1) begin fails++; $display("FAIL hit1_timing got miss=%b lat=%0d want miss=0 lat=1", m, lat); end
    tests_run++;
    if (d !== 32'h22) begin fails++; $display("FAIL hit1_data got %h want 22", d); end
    fetch(32'h8000_000C, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b0 || lat != 1) begin fails++; $display("FAIL hit2_timing got miss=%b lat=%0d want miss=0 lat=1", m, lat); end
    tests_run++;
    if (d !== 32'h44) begin fails++; $display("FAIL hit2_data got %h want 44", d); end
    tests_run++;
    if (hit_count !== 64'd3) begin fails++; $display("FAIL hits_count got %0d want 3", hit_count); end
  endtask

  task automatic test_conflict();
    logic [31:0] d, ma; int lat; logic m, dr;
    fetch(32'h8000_0400, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b1 || ma !== 32'h8000_0400) begin fails++; $display("FAIL evict_refill got miss=%b addr=%h want 1 80000400", m, ma); end
    tests_run++;
    if (d !== 32'h25A5_0400) begin fails++; $display("FAIL evict_data got %h want 25a50400", d); end
    fetch(32'h8000_0000, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b1 || d !== 32'h11) begin fails++; $display("FAIL refetch got miss=%b data=%h want 1 11", m, d); end
    tests_run++;
    if (miss_count !== 64'd3) begin fails++; $display("FAIL evict_misses got %0d want 3", miss_count); end
    tests_run++;
    if (hit_count !== 64'd5) begin fails++; $display("FAIL evict_hits got %0d want 5", hit_count); end
  endtask

  task automatic test_fence();
    logic [31:0] d, ma; int lat; logic m, dr;
    int pulses = 0;
    logic both = 1'b0;
    @(posedge clk); #1;
    fence_i = 1'b1;
    if_read_valid = 1'b1;
    r_addr_i = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      fence_i = 1'b0;
      if_read_valid = 1'b0;
      if (fence_ready) pulses++;
      if (fence_ready && ready_o) both = 1'b1;
    end
    tests_run++;
    if (pulses != 1) begin fails++; $display("FAIL fence_pulses got %0d want 1", pulses); end
    tests_run++;
    if (both !== 1'b0) begin fails++; $display("FAIL fence_overlap got %b want 0", both); end
    tests_run++;
    if (hit_count !== 64'd5 || miss_count !== 64'd3) begin
      fails++; $display("FAIL fence_priority got h=%0d m=%0d want 5 3", hit_count, miss_count);
    end
    fetch(32'h8000_0000, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b1 || d !== 32'h11) begin fails++; $display("FAIL fence_refetch got miss=%b data=%h want 1 11", m, d); end
    tests_run++;
    if (miss_count !== 64'd4) begin fails++; $display("FAIL fence_misses got %0d want 4", miss_count); end
  endtask

  task automatic test_stalled_refill();
    logic [31:0] d, ma; int lat; logic m, dr;
    fetch(32'h8000_0010, 2, 3, d, lat, m, ma, dr);
    tests_run++;
    if (dr !== 1'b0) begin fails++; $display("FAIL stall_req_drop got %b want 0", dr); end
    tests_run++;
    if (lat != 9) begin fails++; $display("FAIL stall_latency got %0d want 9", lat); end
    tests_run++;
    if (d !== 32'h25A5_0010) begin fails++; $display("FAIL stall_w0 got %h want 25a50010", d); end
    fetch(32'h8000_0018, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b0 || d !== 32'h25A5_0018) begin fails++; $display("FAIL stall_w2 got miss=%b data=%h want 0 25a50018", m, d); end
    fetch(32'h8000_001C, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b0 || d !== 32'h25A5_001C) begin fails++; $display("FAIL stall_w3 got miss=%b data=%h want 0 25a5001c", m, d); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d, ma; int lat; logic m, dr;
    @(posedge clk); #1;
    if_read_valid = 1'b1;
    r_addr_i = 32'h8000_0020;
    @(posedge clk); #1;
    if_read_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL mid_req_up got %b want 1", mem_req); end
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = line_word(32'h8000_0020, k);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin fails++; $display("FAIL mid_req_drop got %b want 0", mem_req); end
    tests_run++;
    if (miss_count !== 64'd0) begin fails++; $display("FAIL mid_cnt_clear got %0d want 0", miss_count); end
    @(posedge clk); #1;
    rst = 1'b1;
    fetch(32'h8000_0020, 0, 0, d, lat, m, ma, dr);
    tests_run++;
    if (m !== 1'b1 || ma !== 32'h8000_0020) begin fails++; $display("FAIL mid_refetch got miss=%b addr=%h want 1 80000020", m, ma); end
    tests_run++;
    if (d !== 32'h25A5_0020 || lat != 6) begin fails++; $display("FAIL mid_data got %h lat=%0d want 25a50020 6", d, lat); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_fence();
    test_stalled_refill();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
